// File: rtl/bcd_display_scheduler_pkg.sv
// Shared types and constants for the multiplexed BCD display scheduler:
// conversion state encoding, active-low segment codes and the display limit.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int MAX_DISPLAY = 9999;

endpackage

// File: rtl/bcd_display_scheduler_if.sv
// Bundle between the datapath/board side and the display scheduler.
interface bcd_display_scheduler_if #(
  parameter int DATA_W = 14
);
  // load is a one-cycle strobe, accepted only while busy is low; an accepted
  // load raises busy on the next cycle until the new digits are committed.
  // A load seen while busy is dropped, never queued.
  logic              load;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              overflow;
  logic [1:0]        sel;
  logic [3:0]        an;
  logic [6:0]        seg;
  logic [1:0]        state;

  modport master (
    output load, value,
    input  busy, overflow, sel, an, seg, state
  );

  modport slave (
    input  load, value,
    output busy, overflow, sel, an, seg, state
  );

endinterface

// File: rtl/bcd_display_scheduler_seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment code; non-BCD nibbles go dark.
module seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_DIGIT[0];
      4'd1:    seg_o = SEG_DIGIT[1];
      4'd2:    seg_o = SEG_DIGIT[2];
      4'd3:    seg_o = SEG_DIGIT[3];
      4'd4:    seg_o = SEG_DIGIT[4];
      4'd5:    seg_o = SEG_DIGIT[5];
      4'd6:    seg_o = SEG_DIGIT[6];
      4'd7:    seg_o = SEG_DIGIT[7];
      4'd8:    seg_o = SEG_DIGIT[8];
      4'd9:    seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Serial shift-add-3 binary to BCD converter feeding a four-digit multiplexed
// 7-segment display with leading-zero blanking and overflow dashes.
module bcd_display_scheduler
  import bcd_disp_pkg::*;
#(
  parameter int DATA_W   = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  bcd_display_scheduler_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] SHIFT  = 2'(ST_SHIFT);
  localparam logic [1:0] COMMIT = 2'(ST_COMMIT);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PS_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [15:0]       bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [15:0]       digits_q, digits_d;
  logic              overflow_q, overflow_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [1:0]        sel_q, sel_d;

  logic [DATA_W+15:0] value_ext;
  logic [3:0]         blank;
  logic [3:0]         digit_mux;
  logic [6:0]         digit_seg;

  assign value_ext = {16'b0, bus.value};

  // Add-3 correction on every nibble that would reach 10 or more after the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d      = bus.value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = value_ext > (DATA_W+16)'(MAX_DISPLAY);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d   = bcd_q;
        overflow_d = ovf_pend_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan prescaler runs freely, independent of the converter
  always_comb begin
    presc_d = presc_q + 1'b1;
    sel_d   = sel_q;
    if (presc_q == PS_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      sel_d   = sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      presc_q    <= '0;
      sel_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      presc_q    <= presc_d;
      sel_q      <= sel_d;
    end
  end

  // A slot is blank when it and every more significant digit are zero
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
  end

  assign digit_mux = digits_q[4*sel_q +: 4];

  seg7_decoder u_seg7_decoder (
    .bcd_i (digit_mux),
    .seg_o (digit_seg)
  );

  always_comb begin
    bus.an  = ~(4'b0001 << sel_q);
    bus.seg = digit_seg;
    if (overflow_q) begin
      bus.seg = SEG_DASH;
    end else if (blank[sel_q]) begin
      bus.an  = 4'b1111;
      bus.seg = SEG_BLANK;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = overflow_q;
  assign bus.sel      = sel_q;
  assign bus.state    = state_q;

endmodule

// File: doc/bcd_display_scheduler.md
# bcd_display_scheduler

Sequencing controller for the four-digit multiplexed 7-segment display. It accepts a binary value on a load strobe and converts it to BCD serially with shift-add-3, one bit per clock. It then time-multiplexes the four digits onto a shared active-low segment bus at a prescaled refresh rate, applying leading-zero blanking and overflow indication. It sits between the system datapath (binary result) and the board display pins.

## Interface
- DATA_W, 14: width of binary input; values up to 2^DATA_W-1 accepted, display range 0..9999
- SCAN_DIV, 50000: clk cycles per digit slot (≥2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- load  in  1  one-cycle strobe; capture `value` and start conversion
- value  in  DATA_W  unsigned binary value
- busy  out  1  conversion in progress
- overflow  out  1  last committed value > 9999
- sel  out  2  current digit slot: 0=units, 1=tens, 2=hundreds, 3=thousands
- an  out  4  digit enables, active-low, bit i = slot i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Conversion FSM states:
  - IDLE: on `load`, capture `value` into a shift register, clear the BCD accumulator, then go to SHIFT.
  - SHIFT: runs exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift left one bit from the binary register. Then go to COMMIT.
  - COMMIT: one cycle. Write the four BCD nibbles into the display digit registers, set `overflow` = (captured value > 9999), then go to IDLE.
- `load` outside IDLE is ignored; there is no queueing.
- `load` in the same cycle as `reset`: reset wins.
- Display digit registers hold their value until the next COMMIT.
- Scan behaviour:
  - The prescaler counts 0..SCAN_DIV-1.
  - On the terminal count, `sel` increments modulo 4 (3→0 wraps) and the prescaler restarts at 0.
  - The scan runs continuously, independent of the conversion FSM.
- `an` and `seg` are a combinational decode of registered `sel`, digit registers and `overflow`:
  - Normal: `an` = ~(1<<sel) and `seg` = 7-seg code of digit[sel].
  - Leading-zero blanking: slot i>0 is blanked if digit[i] and every higher digit are 0. A blanked slot drives `an`=4'b1111 and `seg`=7'h7F. Slot 0 is never blanked, so value 0 shows "0".
  - Overflow: all four slots are active with no blanking, `seg`=7'b0111111 (dash).
- Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibble >9 (unreachable) maps to 7'h7F.

## Timing
- Reset values:
  - FSM=IDLE, busy=0, overflow=0, all digits=0.
  - sel=0, prescaler=0, an=4'b1110, seg=7'b1000000.
- `load` sampled high at edge N: busy=1 from cycle N+1 through the COMMIT cycle (N+DATA_W+1) inclusive.
- Digits and `overflow` update at the edge ending COMMIT. They are visible on `seg` from cycle N+DATA_W+2. busy=0 in the same cycle.
- Back-to-back: earliest accepted next `load` is cycle N+DATA_W+2.
- Slot period is exactly SCAN_DIV cycles. The first `sel` change after reset occurs at edge SCAN_DIV.
- A digit commit mid-slot changes `seg` immediately, without waiting for a slot boundary.
- `reset` mid-conversion: abort to IDLE next edge. Digits clear to 0, busy=0. Scan restarts at sel=0.

## Structure
- Package `bcd_disp_pkg`:
  - conversion state enum (IDLE, SHIFT, COMMIT)
  - SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH constants
  - MAX_DISPLAY=9999
- Sub-module `seg7_decoder`: purely combinational 4-bit BCD → 7-bit active-low code. Used once, on the mux output.
- Top contains the conversion FSM with its shift/BCD registers, the prescaler with `sel` counter, the blanking logic and the output mux.

## Test plan
All scenarios use SCAN_DIV=4, DATA_W=14.
- Reset, no load → sel cycles 0,1,2,3,0 every 4 clk. Slot 0 shows an=1110, seg=1000000; slots 1–3 show an=1111, seg=7F.
- load value=1234 → busy high exactly 15 cycles. Slots then show sel0 seg=0011001 (4), sel1 0110000 (3), sel2 0100100 (2), sel3 1111001 (1), all anodes active in turn.
- load value=7 → only slot 0 enabled (seg=1111000); slots 1–3 blanked. Then load 1005 → tens and hundreds show 0, not blanked.
- load value=10000 → overflow=1, all slots active with seg=0111111. Then load 42 → overflow=0, display "42".
- load 1234, then load 9999 while busy → second load ignored and display ends at 1234. Same test with reset asserted at SHIFT cycle 5 → busy=0 next cycle, digits 0, sel=0.
- load asserted on the first IDLE cycle after COMMIT → accepted; busy re-asserts next cycle.
